// File: rtl/prbs_pkg.sv
// Shared PRBS-31 (x^31 + x^28 + 1) definitions for the checker and the TX pattern generator.
package prbs_pkg;

  localparam int PRBS31_ORDER = 31;
  localparam int PRBS31_TAP_A = 31;
  localparam int PRBS31_TAP_B = 28;

  typedef enum logic {
    ST_SEEK   = 1'b0,
    ST_LOCKED = 1'b1
  } prbs_state_e;

  // state[k] holds b(n-31+k); the newest bit enters at the top
  function automatic logic [PRBS31_ORDER-1:0] prbs31_advance(
    input logic [PRBS31_ORDER-1:0] state,
    input int unsigned             nbits
  );
    logic [PRBS31_ORDER-1:0] s;
    logic                    fb;
    s = state;
    for (int unsigned i = 0; i < nbits; i++) begin
      fb = s[PRBS31_ORDER - PRBS31_TAP_A] ^ s[PRBS31_ORDER - PRBS31_TAP_B];
      s  = {fb, s[PRBS31_ORDER-1:1]};
    end
    return s;
  endfunction

endpackage

// File: rtl/prbs31_checker_if.sv
// Received stream word and its qualifier as delivered by the stream manipulator stage.
interface prbs31_checker_if #(
  parameter int DATA_WIDTH = 80
) ();

  logic [DATA_WIDTH-1:0] DATA_IN;
  logic                  DATA_VALID;

  modport master (output DATA_IN, output DATA_VALID);
  modport slave  (input  DATA_IN, input  DATA_VALID);

endinterface

// File: rtl/prbs31_word_gen.sv
// Combinational PRBS-31 word generator: one DATA_WIDTH-bit word (bit 0 earliest) plus the
// successor state. Shared with the TX pattern generator.
module prbs31_word_gen
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH = 80
) (
  input  logic [PRBS31_ORDER-1:0] state_in,
  output logic [DATA_WIDTH-1:0]   word_out,
  output logic [PRBS31_ORDER-1:0] state_out
);

  logic [PRBS31_ORDER-1:0] s_walk;

  always_comb begin
    word_out = '0;
    s_walk   = state_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      s_walk      = prbs31_advance(s_walk, 1);
      word_out[i] = s_walk[PRBS31_ORDER-1];
    end
    state_out = s_walk;
  end

endmodule

// File: rtl/prbs31_checker.sv
// PRBS-31 receive checker: self-seeds, locks after a run of matching words, counts bit errors.
// Optional polarity auto-detection is built when PRBS_CHK_AUTO_INVERT_EN is defined.
//
// state     | meaning
// ST_SEEK   | seeding from received words, counting consecutive predicted matches
// ST_LOCKED | free-running LFSR reference, counting bit errors and checked words
module prbs31_checker
  import prbs_pkg::*;
#(
  parameter int DATA_WIDTH   = 80,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 8,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 USER_CLK,
  input  logic                 RESET_N,
  prbs31_checker_if.slave      stream,
  input  logic                 CLEAR_CNT,
  output logic                 LOCKED,
  output logic                 ERROR,
  output logic [CNT_WIDTH-1:0] BIT_ERR_CNT,
  output logic [CNT_WIDTH-1:0] WORD_CNT,
  output logic                 POLARITY_INV
);

  localparam int MC_W   = $clog2(LOCK_COUNT + 1);
  localparam int ER_W   = $clog2(UNLOCK_COUNT + 1);
  localparam int PC_W   = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W  = ((CNT_WIDTH > PC_W) ? CNT_WIDTH : PC_W) + 1;
  localparam int GRP_W  = 8;
  localparam int GS_W   = $clog2(GRP_W + 1);
  localparam int NGRP   = (DATA_WIDTH + GRP_W - 1) / GRP_W;
  localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [ER_W-1:0] RUN_LAST   = ER_W'(UNLOCK_COUNT - 1);

  prbs_state_e             state;
  logic [PRBS31_ORDER-1:0] lfsr_state;
  logic [PRBS31_ORDER-1:0] next_state;
  logic [PRBS31_ORDER-1:0] data_top;
  logic                    seed_pending;
  logic [MC_W-1:0]         match_cnt;
  logic [ER_W-1:0]         err_run;

  logic [DATA_WIDTH-1:0]   data_in;
  logic                    data_valid;
  logic [DATA_WIDTH-1:0]   exp_word;
  logic [DATA_WIDTH-1:0]   cmp_word;
  logic [DATA_WIDTH-1:0]   diff;
  logic                    word_match;
  logic                    word_err;

  logic [GS_W-1:0]         grp_sum [NGRP];
  logic [PC_W-1:0]         err_bits;
  logic [SUM_W-1:0]        err_sum;
  logic                    err_sat;

  assign data_in    = stream.DATA_IN;
  assign data_valid = stream.DATA_VALID;
  assign data_top   = data_in[DATA_WIDTH-1 -: PRBS31_ORDER];

  // In SEEK lfsr_state holds the seed taken from the previous word; in LOCKED it free-runs.
  prbs31_word_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gen (
    .state_in  (lfsr_state),
    .word_out  (exp_word),
    .state_out (next_state)
  );

`ifdef PRBS_CHK_AUTO_INVERT_EN
  logic                    pol_inv_r;
  logic [MC_W-1:0]         inv_match_cnt;
  logic [DATA_WIDTH-1:0]   inv_gen_word;
  logic [PRBS31_ORDER-1:0] inv_next_state;
  logic                    inv_match;

  // An inverted stream does not obey the recurrence; recover the true stream before predicting.
  prbs31_word_gen #(.DATA_WIDTH(DATA_WIDTH)) u_gen_inv (
    .state_in  (~lfsr_state),
    .word_out  (inv_gen_word),
    .state_out (inv_next_state)
  );

  assign inv_match    = (~data_in == inv_gen_word);
  assign cmp_word     = pol_inv_r ? ~data_in : data_in;
  assign POLARITY_INV = pol_inv_r;
`else
  assign cmp_word     = data_in;
  assign POLARITY_INV = 1'b0;
`endif

  assign diff       = cmp_word ^ exp_word;
  assign word_match = (diff == '0);
  assign word_err   = ~word_match;

  // Two-level adder tree: byte-wide partial counts, then a sum of the partials.
  always_comb begin
    grp_sum  = '{default: '0};
    err_bits = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int b = 0; b < GRP_W; b++) begin
        if (g * GRP_W + b < DATA_WIDTH) begin
          grp_sum[g] = grp_sum[g] + GS_W'(diff[g * GRP_W + b]);
        end
      end
    end
    for (int g = 0; g < NGRP; g++) begin
      err_bits = err_bits + PC_W'(grp_sum[g]);
    end
  end

  assign err_sum = SUM_W'(BIT_ERR_CNT) + SUM_W'(err_bits);
  assign err_sat = |err_sum[SUM_W-1:CNT_WIDTH];

  always_ff @(posedge USER_CLK) begin
    if (!RESET_N) begin
      state         <= ST_SEEK;
      LOCKED        <= 1'b0;
      ERROR         <= 1'b0;
      BIT_ERR_CNT   <= '0;
      WORD_CNT      <= '0;
      lfsr_state    <= '0;
      seed_pending  <= 1'b1;
      match_cnt     <= '0;
      err_run       <= '0;
`ifdef PRBS_CHK_AUTO_INVERT_EN
      pol_inv_r     <= 1'b0;
      inv_match_cnt <= '0;
`endif
    end else begin
      ERROR <= 1'b0;
      if (data_valid) begin
        unique case (state)
          ST_SEEK: begin
            lfsr_state   <= data_top;
            seed_pending <= 1'b0;
            if (!seed_pending) begin
              match_cnt <= word_match ? match_cnt + 1'b1 : '0;
`ifdef PRBS_CHK_AUTO_INVERT_EN
              inv_match_cnt <= inv_match ? inv_match_cnt + 1'b1 : '0;
`endif
              if (word_match && match_cnt == MATCH_LAST) begin
                state     <= ST_LOCKED;
                LOCKED    <= 1'b1;
                match_cnt <= '0;
                err_run   <= '0;
`ifdef PRBS_CHK_AUTO_INVERT_EN
                inv_match_cnt <= '0;
`endif
              end
`ifdef PRBS_CHK_AUTO_INVERT_EN
              else if (inv_match && inv_match_cnt == MATCH_LAST) begin
                state         <= ST_LOCKED;
                LOCKED        <= 1'b1;
                lfsr_state    <= inv_next_state;
                pol_inv_r     <= 1'b1;
                match_cnt     <= '0;
                inv_match_cnt <= '0;
                err_run       <= '0;
              end
`endif
            end
          end
          ST_LOCKED: begin
            lfsr_state  <= next_state;
            ERROR       <= word_err;
            BIT_ERR_CNT <= err_sat ? '1 : err_sum[CNT_WIDTH-1:0];
            if (WORD_CNT != '1) begin
              WORD_CNT <= WORD_CNT + 1'b1;
            end
            if (word_err) begin
              if (err_run == RUN_LAST) begin
                state        <= ST_SEEK;
                LOCKED       <= 1'b0;
                seed_pending <= 1'b1;
                match_cnt    <= '0;
                err_run      <= '0;
`ifdef PRBS_CHK_AUTO_INVERT_EN
                pol_inv_r    <= 1'b0;
`endif
              end else begin
                err_run <= err_run + 1'b1;
              end
            end else begin
              err_run <= '0;
            end
          end
          default: state <= ST_SEEK;
        endcase
      end
      // A clear beats the accumulation of the word sampled on the same edge.
      if (CLEAR_CNT) begin
        BIT_ERR_CNT <= '0;
        WORD_CNT    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// Randomized bench for prbs31_checker against a bit-stream reference model; honours
// PRBS_CHK_AUTO_INVERT_EN when expecting inverted-stream behaviour.
module tb_prbs31_checker;

  localparam int DW       = 80;
  localparam int LOCK_N   = 16;
  localparam int UNLOCK_N = 8;
`ifdef PRBS_CHK_AUTO_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic        user_clk = 1'b0;
  logic        reset_n;
  logic        clear_cnt;
  logic        locked, error, pol_inv;
  logic [31:0] bit_err_cnt, word_cnt;
  logic        sat_locked, sat_error, sat_pol_inv;
  logic [3:0]  sat_bit_err_cnt, sat_word_cnt;

  int n_checks = 0;
  int n_errors = 0;

  prbs31_checker_if #(.DATA_WIDTH(DW)) stream_if ();

  prbs31_checker #(.DATA_WIDTH(DW)) dut (
    .USER_CLK     (user_clk),
    .RESET_N      (reset_n),
    .stream       (stream_if),
    .CLEAR_CNT    (clear_cnt),
    .LOCKED       (locked),
    .ERROR        (error),
    .BIT_ERR_CNT  (bit_err_cnt),
    .WORD_CNT     (word_cnt),
    .POLARITY_INV (pol_inv)
  );

  prbs31_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_sat (
    .USER_CLK     (user_clk),
    .RESET_N      (reset_n),
    .stream       (stream_if),
    .CLEAR_CNT    (clear_cnt),
    .LOCKED       (sat_locked),
    .ERROR        (sat_error),
    .BIT_ERR_CNT  (sat_bit_err_cnt),
    .WORD_CNT     (sat_word_cnt),
    .POLARITY_INV (sat_pol_inv)
  );

  always #5 user_clk = ~user_clk;

  // reference model state
  bit              m_locked = 0, m_error = 0, m_pol = 0, m_seeded = 0;
  int              m_match = 0, m_inv_match = 0, m_err_run = 0;
  longint unsigned m_err_sum = 0, m_word_sum = 0;
  logic [DW-1:0]   m_prev = '0, m_last = '0;

  bit              txq[$];
  bit              tx_inv = 0;
  logic [DW-1:0]   fm;
  logic            clr;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic longint unsigned sat_at(input longint unsigned v, input int w);
    longint unsigned mx;
    mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  // Next word from the rule b(n) = b(n-31) ^ b(n-28), using the last 31 bits of prev.
  function automatic logic [DW-1:0] predict(input logic [DW-1:0] prev);
    bit            h [31+DW];
    logic [DW-1:0] r;
    for (int i = 0; i < 31; i++) h[i] = prev[DW-31+i];
    for (int n = 31; n < 31 + DW; n++) h[n] = h[n-31] ^ h[n-28];
    for (int i = 0; i < DW; i++) r[i] = h[31+i];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  task automatic next_tx(output logic [DW-1:0] w);
    bit nb;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      nb   = txq[0] ^ txq[3];
      w[i] = nb;
      txq.push_back(nb);
      void'(txq.pop_front());
    end
  endtask

  task automatic model_edge(input logic [DW-1:0] d, input logic v, input logic c, input logic rn);
    logic [DW-1:0] exp_w;
    int            nerr;
    bit            pm, im;
    if (!rn) begin
      m_locked = 0; m_error = 0; m_pol = 0; m_seeded = 0;
      m_match = 0; m_inv_match = 0; m_err_run = 0;
      m_err_sum = 0; m_word_sum = 0;
    end else begin
      m_error = 0;
      if (v) begin
        if (!m_locked) begin
          if (m_seeded) begin
            pm = (d == predict(m_prev));
            im = INV_EN && (d == ~predict(~m_prev));
            m_match     = pm ? m_match + 1 : 0;
            m_inv_match = im ? m_inv_match + 1 : 0;
            if (m_match == LOCK_N) begin
              m_locked = 1; m_pol = 0; m_last = d;
            end else if (m_inv_match == LOCK_N) begin
              m_locked = 1; m_pol = 1; m_last = ~d;
            end
            if (m_locked) begin
              m_match = 0; m_inv_match = 0; m_err_run = 0;
            end
          end
          m_seeded = 1;
          m_prev   = d;
        end else begin
          exp_w      = predict(m_last);
          m_last     = exp_w;
          nerr       = $countones((m_pol ? ~d : d) ^ exp_w);
          m_err_sum  = m_err_sum + longint'(nerr);
          m_word_sum = m_word_sum + 1;
          m_error    = (nerr != 0);
          if (nerr != 0) begin
            m_err_run++;
            if (m_err_run == UNLOCK_N) begin
              m_locked = 0; m_seeded = 0; m_pol = 0; m_match = 0; m_inv_match = 0; m_err_run = 0;
            end
          end else begin
            m_err_run = 0;
          end
        end
      end
      if (c) begin
        m_err_sum  = 0;
        m_word_sum = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk_eq("locked",       64'(locked),          64'(m_locked));
    chk_eq("error",        64'(error),           64'(m_error));
    chk_eq("polarity_inv", 64'(pol_inv),         64'(m_pol));
    chk_eq("bit_err_cnt",  64'(bit_err_cnt),     sat_at(m_err_sum, 32));
    chk_eq("word_cnt",     64'(word_cnt),        sat_at(m_word_sum, 32));
    chk_eq("sat_locked",   64'(sat_locked),      64'(m_locked));
    chk_eq("sat_error",    64'(sat_error),       64'(m_error));
    chk_eq("sat_pol",      64'(sat_pol_inv),     64'(m_pol));
    chk_eq("sat_bit_err",  64'(sat_bit_err_cnt), sat_at(m_err_sum, 4));
    chk_eq("sat_word_cnt", 64'(sat_word_cnt),    sat_at(m_word_sum, 4));
  endtask

  task automatic step(input logic [DW-1:0] d, input logic v, input logic c, input logic rn);
    @(negedge user_clk);
    stream_if.DATA_IN    = d;
    stream_if.DATA_VALID = v;
    clear_cnt            = c;
    reset_n              = rn;
    @(posedge user_clk);
    model_edge(d, v, c, rn);
    #1;
    compare_all();
  endtask

  task automatic send_word(input logic [DW-1:0] flip, input logic c);
    logic [DW-1:0] w;
    next_tx(w);
    step((tx_inv ? ~w : w) ^ flip, 1'b1, c, 1'b1);
  endtask

  task automatic one_bit_mask();
    fm = '0;
    fm[$urandom_range(0, DW-1)] = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n              = 1'b0;
    clear_cnt            = 1'b0;
    stream_if.DATA_IN    = '0;
    stream_if.DATA_VALID = 1'b0;
    for (int i = 0; i < 31; i++) txq.push_back(1'b1);

    // reset with random input
    repeat (2) step(rand_word(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    chk_eq("rst_locked",  64'(locked),      64'd0);
    chk_eq("rst_error",   64'(error),       64'd0);
    chk_eq("rst_bit_err", 64'(bit_err_cnt), 64'd0);
    chk_eq("rst_word",    64'(word_cnt),    64'd0);

    // clean lock from seed all-ones
    for (int i = 1; i <= 17; i++) begin
      send_word('0, 1'b0);
      if (i == 16) chk_eq("prelock_16", 64'(locked), 64'd0);
    end
    chk_eq("lock_17",      64'(locked),      64'd1);
    chk_eq("lock_bit_err", 64'(bit_err_cnt), 64'd0);
    chk_eq("lock_word0",   64'(word_cnt),    64'd0);
    send_word('0, 1'b0);
    chk_eq("lock_word1",   64'(word_cnt),    64'd1);
    repeat (5) send_word('0, 1'b0);

    // single error, bits 0 and 5
    fm = '0; fm[0] = 1'b1; fm[5] = 1'b1;
    send_word(fm, 1'b0);
    chk_eq("single_error",   64'(error),       64'd1);
    chk_eq("single_bit_err", 64'(bit_err_cnt), 64'd2);
    chk_eq("single_locked",  64'(locked),      64'd1);
    send_word('0, 1'b0);
    chk_eq("single_err_gone", 64'(error),      64'd0);

    // loss of lock and relock
    send_word('0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      one_bit_mask();
      send_word(fm, 1'b0);
      if (i == 7) chk_eq("unlock_hold_7", 64'(locked), 64'd1);
    end
    chk_eq("unlock_8",       64'(locked),      64'd0);
    chk_eq("unlock_bit_err", 64'(bit_err_cnt), 64'd8);
    for (int i = 1; i <= 17; i++) begin
      send_word('0, 1'b0);
      if (i == 16) chk_eq("relock_pre", 64'(locked), 64'd0);
    end
    chk_eq("relock",         64'(locked),      64'd1);
    chk_eq("relock_bit_err", 64'(bit_err_cnt), 64'd8);

    // mid-operation reset, then alternating valid
    step(rand_word(), 1'b1, 1'b0, 1'b0);
    chk_eq("midrst_locked",  64'(locked),      64'd0);
    chk_eq("midrst_bit_err", 64'(bit_err_cnt), 64'd0);
    for (int c = 1; c <= 34; c++) begin
      if (c % 2 == 1) send_word('0, 1'b0);
      else step(rand_word(), 1'b0, 1'b0, 1'b1);
      if (c == 32) chk_eq("gap_prelock", 64'(locked), 64'd0);
    end
    chk_eq("gap_lock", 64'(locked), 64'd1);
    one_bit_mask();
    send_word(fm, 1'b1);
    chk_eq("clr_bit_err", 64'(bit_err_cnt), 64'd0);
    chk_eq("clr_error",   64'(error),       64'd1);
    step(rand_word(), 1'b0, 1'b0, 1'b1);
    chk_eq("idle_error",  64'(error),       64'd0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      fm  = '0;
      clr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 9) < 7) begin
        if ($urandom_range(0, 15) == 0) begin
          repeat ($urandom_range(1, 3)) fm[$urandom_range(0, DW-1)] = 1'b1;
        end
        send_word(fm, clr);
      end else begin
        step(rand_word(), 1'b0, clr, 1'b1);
      end
    end

    // saturation on the 4-bit instance
    step(rand_word(), 1'b0, 1'b0, 1'b0);
    repeat (17) send_word('0, 1'b0);
    send_word('0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      one_bit_mask();
      send_word(fm, 1'b0);
      send_word('0, 1'b0);
    end
    chk_eq("sat_bit_err_15", 64'(sat_bit_err_cnt), 64'd15);
    chk_eq("sat_word_15",    64'(sat_word_cnt),    64'd15);
    chk_eq("wide_bit_err",   64'(bit_err_cnt),     64'd20);
    chk_eq("wide_word",      64'(word_cnt),        64'd40);

    // inverted stream
    step(rand_word(), 1'b0, 1'b0, 1'b0);
    tx_inv = 1'b1;
    repeat (30) send_word('0, 1'b0);
    chk_eq("inv_locked", 64'(locked),  64'(INV_EN));
    chk_eq("inv_pol",    64'(pol_inv), 64'(INV_EN));
    one_bit_mask();
    send_word(fm, 1'b0);
    chk_eq("inv_error",  64'(error),   64'(INV_EN));
    tx_inv = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prbs31_checker.md
Name: prbs31_checker

Overview:
- Receive-side test block directly downstream of the 80-bit stream manipulator stage on USER_CLK.
- Checks the stream manipulator's output against a PRBS-31 sequence (x^31 + x^28 + 1).
- Self-seeds from received data, declares lock after a run of matching words, then counts bit errors with saturation.
- Used for Genesys 2 link bring-up and bit-error-rate measurement.

Parameters:
DATA_WIDTH, 80, stream word width; must be >= 31.
LOCK_COUNT, 16, consecutive matching words required to lock.
UNLOCK_COUNT, 8, consecutive errored words that drop lock.
CNT_WIDTH, 32, width of the error and word counters.

Ports:
USER_CLK  input  1  sole clock; all logic on rising edge.
RESET_N  input  1  synchronous reset, active-low.
DATA_IN  input  DATA_WIDTH  received word; bit 0 is the earliest bit in time.
DATA_VALID  input  1  DATA_IN is valid this cycle.
CLEAR_CNT  input  1  synchronous clear of BIT_ERR_CNT and WORD_CNT.
LOCKED  output  1  checker is in LOCKED state.
ERROR  output  1  previous valid word contained at least one bit error (LOCKED only).
BIT_ERR_CNT  output  CNT_WIDTH  accumulated bit errors, saturating.
WORD_CNT  output  CNT_WIDTH  words checked while LOCKED, saturating.
POLARITY_INV  output  1  stream detected as inverted (see Optional Feature).

Behaviour:
- Interface: one clock (USER_CLK); reset is synchronous and active-low (RESET_N).
- Reset values: LOCKED=0, ERROR=0, BIT_ERR_CNT=0, WORD_CNT=0, POLARITY_INV=0, state=SEEK, match_cnt=0, err_run=0, seed/LFSR state=0.
- Sequence rule: b(n) = b(n-31) XOR b(n-28), bit order as on DATA_IN. The next-word prediction from a 31-bit state is combinational and unrolled DATA_WIDTH steps.
- All state changes occur only on cycles with DATA_VALID=1. When DATA_VALID=0, state, counters and LFSR hold, and ERROR is driven 0 on the next cycle.
- SEEK state:
  - The first valid word after entry loads the seed: DATA_IN[DATA_WIDTH-1 -: 31].
  - Each later valid word is compared with the prediction from the previous word.
  - Match: match_cnt+1 and reseed from the current word.
  - Mismatch: match_cnt=0 and reseed from the current word.
  - When match_cnt reaches LOCK_COUNT, go to LOCKED. The LFSR takes the state of the word that completed the count.
- LOCKED state:
  - The prediction comes from the internal LFSR only; received data never reseeds it.
  - err_bits = popcount(DATA_IN XOR expected).
  - BIT_ERR_CNT += err_bits; WORD_CNT += 1; both saturate at all-ones with no wrap.
  - ERROR = (err_bits != 0).
  - An errored word increments err_run; a clean word clears it.
  - When err_run reaches UNLOCK_COUNT, go to SEEK with match_cnt=0 and seed pending. Counters retain their values.
- Latency: LOCKED, ERROR and the counters are registered; they reflect a word 1 cycle after the edge on which that word is sampled valid.
- CLEAR_CNT and an errored word in the same cycle: the clear wins and that word's errors are discarded. ERROR still reports that word.
- Reset mid-operation returns to the reset values on the next edge, regardless of DATA_VALID.
- Popcount is adder-tree, combinational within one cycle; there is no pipelining at DATA_WIDTH=80.

Optional Feature:
- Macro PRBS_CHK_AUTO_INVERT_EN.
- When defined:
  - In SEEK, the checker also compares against the inverted prediction.
  - If the inverted comparison produces LOCK_COUNT consecutive matches, lock on the inverted stream and set POLARITY_INV=1 until the next SEEK entry.
  - In LOCKED, DATA_IN is XORed with all-ones before comparison while POLARITY_INV=1.
- When undefined: no inverted comparison is performed and POLARITY_INV is tied to 0.

Decomposition:
- Package prbs_pkg holds:
  - PRBS31_ORDER=31 and the tap constants 31/28;
  - the state enum {SEEK, LOCKED};
  - a function prbs31_advance(state, nbits).
- One sub-module: prbs31_word_gen, combinational. It takes a 31-bit state and returns the DATA_WIDTH-bit word plus the next state. The matching TX pattern generator reuses it.

Test Plan:
- Reset: hold RESET_N=0 for 2 cycles with random DATA_IN -> LOCKED=0, ERROR=0, both counters 0.
- Clean lock: PRBS-31 from seed all-ones, DATA_VALID=1 continuously -> LOCKED rises 1 cycle after the 17th word; BIT_ERR_CNT stays 0; WORD_CNT counts from 0.
- Single error: locked, flip bits 0 and 5 of one word -> ERROR=1 for exactly 1 cycle; BIT_ERR_CNT=2; LOCKED stays 1.
- Loss of lock: 8 consecutive words each with 1 flipped bit -> LOCKED drops after the 8th, BIT_ERR_CNT=8. Then clean data -> relock after 17 valid words with BIT_ERR_CNT held at 8.
- Valid gaps and clear: DATA_VALID alternating 1/0 -> lock after 17 valid words, 34 cycles. CLEAR_CNT in the same cycle as an errored word -> BIT_ERR_CNT=0 and ERROR=1.
- Saturation and inversion: CNT_WIDTH=4 with 20 single-bit errors -> BIT_ERR_CNT=15. With PRBS_CHK_AUTO_INVERT_EN, an inverted stream -> LOCKED=1 and POLARITY_INV=1; without the macro, the same stream never locks.
